// File: rtl/traffic_lights_pkg.sv
// Shared definitions for the traffic light controller and its command sequencer:
// command/request encodings, timing field width, reset timing defaults and the
// request payload struct.
package traffic_lights_pkg;

  localparam int unsigned TIME_W = 16;

  // Command codes understood by the controller's command port.
  typedef enum logic [2:0] {
    CMD_ON         = 3'b000,
    CMD_OFF        = 3'b001,
    CMD_BLINK      = 3'b010,
    CMD_SET_GREEN  = 3'b011,
    CMD_SET_RED    = 3'b100,
    CMD_SET_YELLOW = 3'b101
  } cmd_type_t;

  // High-level request operations accepted by the sequencer.
  typedef enum logic [1:0] {
    OP_ON       = 2'd0,
    OP_OFF      = 2'd1,
    OP_BLINK    = 2'd2,
    OP_RECONFIG = 2'd3
  } req_op_t;

  // Controller timing values after reset, in ms.
  localparam logic [TIME_W-1:0] RST_RED_MS    = 16'd100;
  localparam logic [TIME_W-1:0] RST_YELLOW_MS = 16'd30;
  localparam logic [TIME_W-1:0] RST_GREEN_MS  = 16'd50;

  // Latched request payload; a zero timing field means "leave unchanged".
  typedef struct packed {
    req_op_t           op;
    logic [TIME_W-1:0] green_ms;
    logic [TIME_W-1:0] red_ms;
    logic [TIME_W-1:0] yellow_ms;
  } seq_req_t;

endpackage

// File: rtl/traffic_lights_cmd_seq.sv
// Command sequencer for the traffic light controller.
// Accepts ON/OFF/BLINK/RECONFIG requests over valid/ready and expands each into
// single-cycle command pulses, wrapping timing writes in a blink window and
// inserting CMD_GAP_CYCLES idle cycles after every pulse.
// Ports:
//   clk_i, rst_ni          clock, async active-low reset
//   req_valid_i/ready_o    request handshake (ready high only in IDLE)
//   req_op_i               0 ON, 1 OFF, 2 BLINK, 3 RECONFIG
//   req_*_ms_i             new timing values, 0 = leave unchanged
//   cmd_valid_o            one-cycle command strobe
//   cmd_type_o/cmd_data_o  command code and SET_* value, 0 outside strobes
//   busy_o                 sequencer not idle
module traffic_lights_cmd_seq
  import traffic_lights_pkg::*;
#(
  parameter int unsigned CMD_GAP_CYCLES = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [1:0]        req_op_i,
  input  logic [TIME_W-1:0] req_green_ms_i,
  input  logic [TIME_W-1:0] req_red_ms_i,
  input  logic [TIME_W-1:0] req_yellow_ms_i,
  output logic              cmd_valid_o,
  output logic [2:0]        cmd_type_o,
  output logic [TIME_W-1:0] cmd_data_o,
  output logic              busy_o
);

  localparam int unsigned CNT_W =
    (CMD_GAP_CYCLES > 0) ? $clog2(CMD_GAP_CYCLES + 1) : 1;
  // GAP counts down from GAP_LOAD to 0, giving CMD_GAP_CYCLES cycles in GAP.
  localparam logic [CNT_W-1:0] GAP_LOAD =
    (CMD_GAP_CYCLES > 0) ? CNT_W'(CMD_GAP_CYCLES - 1) : '0;

  // S_OFF carries the OFF pulse; ON requests reuse S_PRE_ON for their ON pulse.
  typedef enum logic [3:0] {
    S_IDLE,
    S_PRE_ON,
    S_OFF,
    S_BLINK,
    S_SET_G,
    S_SET_R,
    S_SET_Y,
    S_POST_ON,
    S_GAP
  } state_t;

  state_t            state_q, state_d;
  state_t            ret_q, ret_d;
  logic [CNT_W-1:0]  gap_cnt_q, gap_cnt_d;
  seq_req_t          req_q, req_in;
  logic              light_off_q;
  logic              accept;

  logic              cmd_valid_d;
  cmd_type_t         cmd_type_d;
  logic [TIME_W-1:0] cmd_data_d;
  logic              busy_d;
  logic              ready_d;

  // Issuing step that follows `cur` for request `r`; S_IDLE as `cur` yields the first step.
  function automatic state_t next_step(input state_t cur, input seq_req_t r,
                                       input logic off);
    state_t nxt;
    nxt = S_IDLE;
    case (cur)
      S_IDLE: begin
        case (r.op)
          OP_ON:   nxt = S_PRE_ON;
          OP_OFF:  nxt = S_OFF;
          default: nxt = off ? S_PRE_ON : S_BLINK;  // controller ignores BLINK while off
        endcase
      end
      S_PRE_ON: nxt = (r.op == OP_ON) ? S_IDLE : S_BLINK;
      S_BLINK: begin
        if (r.op == OP_BLINK)      nxt = S_IDLE;
        else if (r.green_ms != '0) nxt = S_SET_G;
        else if (r.red_ms != '0)   nxt = S_SET_R;
        else if (r.yellow_ms != '0) nxt = S_SET_Y;
        else                       nxt = S_POST_ON;
      end
      S_SET_G: begin
        if (r.red_ms != '0)         nxt = S_SET_R;
        else if (r.yellow_ms != '0) nxt = S_SET_Y;
        else                        nxt = S_POST_ON;
      end
      S_SET_R: nxt = (r.yellow_ms != '0) ? S_SET_Y : S_POST_ON;
      S_SET_Y: nxt = S_POST_ON;
      default: nxt = S_IDLE;
    endcase
    return nxt;
  endfunction

  // Incoming request payload.
  always_comb begin
    req_in.op        = req_op_t'(req_op_i);
    req_in.green_ms  = req_green_ms_i;
    req_in.red_ms    = req_red_ms_i;
    req_in.yellow_ms = req_yellow_ms_i;
  end

  assign accept = req_valid_i && (state_q == S_IDLE);

  // State register plus registered outputs, latched request and light_off flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      ret_q       <= S_IDLE;
      gap_cnt_q   <= '0;
      req_q       <= '0;
      light_off_q <= 1'b0;
      cmd_valid_o <= 1'b0;
      cmd_type_o  <= 3'b000;
      cmd_data_o  <= '0;
      busy_o      <= 1'b0;
      req_ready_o <= 1'b1;
    end else begin
      state_q   <= state_d;
      ret_q     <= ret_d;
      gap_cnt_q <= gap_cnt_d;
      if (accept) begin
        req_q <= req_in;
      end
      if (state_d == S_OFF) begin
        light_off_q <= 1'b1;
      end else if ((state_d == S_PRE_ON) || (state_d == S_POST_ON)) begin
        light_off_q <= 1'b0;
      end
      cmd_valid_o <= cmd_valid_d;
      cmd_type_o  <= 3'(cmd_type_d);
      cmd_data_o  <= cmd_data_d;
      busy_o      <= busy_d;
      req_ready_o <= ready_d;
    end
  end

  // Next-state logic: every issuing state lasts one cycle, then GAP (or straight on when gap is 0).
  always_comb begin
    state_d   = state_q;
    ret_d     = ret_q;
    gap_cnt_d = gap_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          state_d = next_step(S_IDLE, req_in, light_off_q);
        end
      end
      S_GAP: begin
        if (gap_cnt_q == '0) begin
          state_d = ret_q;
        end else begin
          gap_cnt_d = gap_cnt_q - CNT_W'(1);
        end
      end
      default: begin
        if (CMD_GAP_CYCLES == 0) begin
          state_d = next_step(state_q, req_q, light_off_q);
        end else begin
          state_d   = S_GAP;
          ret_d     = next_step(state_q, req_q, light_off_q);
          gap_cnt_d = GAP_LOAD;
        end
      end
    endcase
  end

  // Output decode from the next state so registered outputs line up with the state.
  always_comb begin
    cmd_valid_d = 1'b0;
    cmd_type_d  = CMD_ON;
    cmd_data_d  = '0;
    busy_d      = (state_d != S_IDLE);
    ready_d     = (state_d == S_IDLE);
    case (state_d)
      S_PRE_ON, S_POST_ON: begin
        cmd_valid_d = 1'b1;
        cmd_type_d  = CMD_ON;
      end
      S_OFF: begin
        cmd_valid_d = 1'b1;
        cmd_type_d  = CMD_OFF;
      end
      S_BLINK: begin
        cmd_valid_d = 1'b1;
        cmd_type_d  = CMD_BLINK;
      end
      S_SET_G: begin
        cmd_valid_d = 1'b1;
        cmd_type_d  = CMD_SET_GREEN;
        cmd_data_d  = req_q.green_ms;
      end
      S_SET_R: begin
        cmd_valid_d = 1'b1;
        cmd_type_d  = CMD_SET_RED;
        cmd_data_d  = req_q.red_ms;
      end
      S_SET_Y: begin
        cmd_valid_d = 1'b1;
        cmd_type_d  = CMD_SET_YELLOW;
        cmd_data_d  = req_q.yellow_ms;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_traffic_lights_cmd_seq.sv
// Bench for traffic_lights_cmd_seq: one instance with a 2-cycle gap, one with no gap.
// Each accepted request is expanded into expected pulses (cycle, type, data) on a
// per-instance queue; a negedge monitor pops and compares them against the DUT.
module tb_traffic_lights_cmd_seq;
  import traffic_lights_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        rv [2];
  logic [1:0]  rop [2];
  logic [15:0] rg [2];
  logic [15:0] rr [2];
  logic [15:0] ry [2];
  logic        rdy [2];
  logic        cv [2];
  logic        bsy [2];
  logic [2:0]  ct [2];
  logic [15:0] cd [2];

  traffic_lights_cmd_seq #(.CMD_GAP_CYCLES(2)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(rv[0]), .req_ready_o(rdy[0]), .req_op_i(rop[0]),
    .req_green_ms_i(rg[0]), .req_red_ms_i(rr[0]), .req_yellow_ms_i(ry[0]),
    .cmd_valid_o(cv[0]), .cmd_type_o(ct[0]), .cmd_data_o(cd[0]), .busy_o(bsy[0])
  );

  traffic_lights_cmd_seq #(.CMD_GAP_CYCLES(0)) dut_nogap (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(rv[1]), .req_ready_o(rdy[1]), .req_op_i(rop[1]),
    .req_green_ms_i(rg[1]), .req_red_ms_i(rr[1]), .req_yellow_ms_i(ry[1]),
    .cmd_valid_o(cv[1]), .cmd_type_o(ct[1]), .cmd_data_o(cd[1]), .busy_o(bsy[1])
  );

  typedef struct {
    int          cyc;
    logic [2:0]  typ;
    logic [15:0] data;
  } pulse_t;

  pulse_t q0[$];
  pulse_t q1[$];
  int     vectors = 0;
  int     miscompares = 0;
  int     cyc = 0;
  logic   light_off_m [2];
  int     exp_idle [2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_pulse(input int i, input int t, input logic [2:0] typ, input logic [15:0] data);
    pulse_t p;
    p.cyc = t; p.typ = typ; p.data = data;
    if (i == 0) q0.push_back(p);
    else        q1.push_back(p);
  endtask

  // Reference expansion of one request accepted in cycle a.
  task automatic expect_req(input int i, input logic [1:0] op, input logic [15:0] g,
                            input logic [15:0] r, input logic [15:0] y, input int a);
    int gap;
    int t;
    gap = (i == 0) ? 2 : 0;
    t = a + 1;
    case (op)
      2'd0: begin push_pulse(i, t, 3'b000, 16'h0); t += gap + 1; light_off_m[i] = 1'b0; end
      2'd1: begin push_pulse(i, t, 3'b001, 16'h0); t += gap + 1; light_off_m[i] = 1'b1; end
      default: begin
        if (light_off_m[i]) begin push_pulse(i, t, 3'b000, 16'h0); t += gap + 1; end
        push_pulse(i, t, 3'b010, 16'h0); t += gap + 1;
        if (op == 2'd3) begin
          if (g != 0) begin push_pulse(i, t, 3'b011, g); t += gap + 1; end
          if (r != 0) begin push_pulse(i, t, 3'b100, r); t += gap + 1; end
          if (y != 0) begin push_pulse(i, t, 3'b101, y); t += gap + 1; end
          push_pulse(i, t, 3'b000, 16'h0); t += gap + 1;
        end
        light_off_m[i] = 1'b0;
      end
    endcase
    exp_idle[i] = t;
  endtask

  // Compare one instance's outputs for the current cycle against its queue.
  task automatic mon(input int i);
    pulse_t p;
    logic   have;
    have = (i == 0) ? (q0.size() > 0) : (q1.size() > 0);
    if (have) p = (i == 0) ? q0[0] : q1[0];
    if (cv[i]) begin
      if (!have) begin
        check_eq($sformatf("unexpected_pulse%0d", i), 32'(cv[i]), 32'd0);
      end else begin
        if (i == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
        check_eq($sformatf("pulse_cycle%0d", i), 32'(cyc), 32'(p.cyc));
        check_eq($sformatf("pulse_type%0d", i), 32'(ct[i]), 32'(p.typ));
        check_eq($sformatf("pulse_data%0d", i), 32'(cd[i]), 32'(p.data));
      end
    end else begin
      check_eq($sformatf("idle_type_data%0d", i), {13'd0, ct[i], cd[i]}, 32'd0);
      if (have && (p.cyc <= cyc)) begin
        check_eq($sformatf("missing_pulse%0d", i), 32'(cv[i]), 32'd1);
        if (i == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 2; k++) mon(k);
    end
  end

  // Present a request (called at a negedge) and wait for acceptance.
  task automatic send(input int i, input logic [1:0] op, input logic [15:0] g,
                      input logic [15:0] r, input logic [15:0] y,
                      input bit hold, input bit chk_accept);
    int n;
    int a;
    int prev_idle;
    prev_idle = exp_idle[i];
    rv[i] = 1'b1; rop[i] = op; rg[i] = g; rr[i] = r; ry[i] = y;
    n = 0;
    while (!rdy[i] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      check_eq("ready_timeout", 32'(rdy[i]), 32'd1);
      rv[i] = 1'b0;
      return;
    end
    a = cyc;
    if (chk_accept) check_eq("held_accept_cycle", 32'(a), 32'(prev_idle));
    expect_req(i, op, g, r, y, a);
    @(negedge clk);
    if (!hold) rv[i] = 1'b0;
    check_eq($sformatf("busy_after_accept%0d", i), {30'd0, bsy[i], rdy[i]}, 32'b10);
  endtask

  task automatic wait_idle(input int i);
    int n;
    n = 0;
    while (!rdy[i] && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq($sformatf("ready_cycle%0d", i), 32'(cyc), 32'(exp_idle[i]));
    check_eq($sformatf("idle_busy%0d", i), 32'(bsy[i]), 32'd0);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      rv[k] = 1'b0; rop[k] = 2'd0; rg[k] = '0; rr[k] = '0; ry[k] = '0;
      light_off_m[k] = 1'b0; exp_idle[k] = 0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check_eq($sformatf("rst_ready%0d", k), 32'(rdy[k]), 32'd1);
      check_eq($sformatf("rst_busy%0d", k), 32'(bsy[k]), 32'd0);
      check_eq($sformatf("rst_cmd%0d", k), {12'd0, cv[k], ct[k], cd[k]}, 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // OFF, then BLINK while off (ON precedes BLINK), then RECONFIG g/y with light on.
    send(0, 2'd1, 16'h0, 16'h0, 16'h0, 0, 0); wait_idle(0);
    send(0, 2'd2, 16'h0, 16'h0, 16'h0, 0, 0); wait_idle(0);
    send(0, 2'd3, 16'h0040, 16'h0, 16'h0020, 0, 0); wait_idle(0);
    send(0, 2'd2, 16'h0, 16'h0, 16'h0, 0, 0); wait_idle(0);
    send(0, 2'd3, 16'h0, 16'h0, 16'h0, 0, 0); wait_idle(0);
    send(0, 2'd0, 16'h0, 16'h0, 16'h0, 0, 0); wait_idle(0);

    // Valid held through a RECONFIG: next request taken the cycle ready rises.
    send(0, 2'd3, 16'h1234, 16'h5678, 16'h9abc, 1, 0);
    send(0, 2'd1, 16'h0, 16'h0, 16'h0, 0, 1); wait_idle(0);
    send(0, 2'd3, 16'h0, 16'h0007, 16'h0, 0, 0); wait_idle(0);

    // No-gap instance: five consecutive pulses, then a few more ops.
    send(1, 2'd3, 16'h0001, 16'h0002, 16'h0003, 0, 0); wait_idle(1);
    send(1, 2'd1, 16'h0, 16'h0, 16'h0, 0, 0); wait_idle(1);
    send(1, 2'd3, 16'hffff, 16'h0, 16'h8000, 0, 0); wait_idle(1);

    // Random requests on both instances.
    for (int n = 0; n < 16; n++) begin
      int k;
      k = n % 2;
      send(k, 2'($urandom_range(0, 3)),
           $urandom_range(0, 1) ? 16'($urandom) : 16'h0,
           $urandom_range(0, 1) ? 16'($urandom) : 16'h0,
           $urandom_range(0, 1) ? 16'($urandom) : 16'h0, 0, 0);
      wait_idle(k);
    end

    // Reset between the SET_G and SET_R pulses.
    send(0, 2'd0, 16'h0, 16'h0, 16'h0, 0, 0); wait_idle(0);
    send(0, 2'd3, 16'h0011, 16'h0022, 16'h0033, 0, 0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", 32'(cv[0]), 32'd0);
    check_eq("mid_rst_busy", 32'(bsy[0]), 32'd0);
    check_eq("mid_rst_ready", 32'(rdy[0]), 32'd1);
    q0.delete();
    q1.delete();
    light_off_m[0] = 1'b0;
    light_off_m[1] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check_eq("post_rst_ready", 32'(rdy[0]), 32'd1);
    check_eq("post_rst_busy", 32'(bsy[0]), 32'd0);

    // Light is on after reset: BLINK must be a single pulse.
    send(0, 2'd2, 16'h0, 16'h0, 16'h0, 0, 0); wait_idle(0);

    repeat (3) @(negedge clk);
    check_eq("queue0_drained", 32'(q0.size()), 32'd0);
    check_eq("queue1_drained", 32'(q1.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
